// File: rtl/pe_pkg.sv
// Shared types and Q-format constants for the PE result path.
package pe_pkg;

  typedef enum logic [1:0] {
    GEMM = 2'b00,
    DIV  = 2'b01,
    EXP  = 2'b10,
    LOG  = 2'b11
  } gemm_uno_e;

  localparam int DEF_INT_BW = 5;
  localparam int DEF_FRA_BW = 10;
  localparam int DEF_MUL_BW = 1 + DEF_INT_BW + DEF_FRA_BW;
  localparam int DEF_ACC_BW = 32;
  localparam int DEF_DEPTH  = 4;

  localparam logic [DEF_MUL_BW-1:0] MUL_MAX = {1'b0, {(DEF_MUL_BW-1){1'b1}}};
  localparam logic [DEF_MUL_BW-1:0] MUL_MIN = {1'b1, {(DEF_MUL_BW-1){1'b0}}};

  typedef struct packed {
    logic [DEF_MUL_BW-1:0] data;
    gemm_uno_e             mode;
    logic                  sat;
  } drain_entry_t;

endpackage

// File: rtl/drain_fifo.sv
// Synchronous FIFO of drain entries; a push while full is only accepted with a same-cycle pop.
module drain_fifo
  import pe_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  drain_entry_t     wr_entry_i,
  input  logic             pop_i,
  output drain_entry_t     rd_entry_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;
  drain_entry_t     mem_q [DEPTH];

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign count_o    = count_q;
  assign rd_entry_o = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop_ok   = pop_i & ~empty_o & ~clr_i;
    push_ok  = push_i & (~full_o | pop_ok) & ~clr_i;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; occupancy gates validity, so stale words are never observed.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_entry_i;
  end

endmodule

// File: rtl/pe_out_drain.sv
// PE column drain: round-half-up requantize, saturate, buffer in a FIFO and flag drops.
module pe_out_drain
  import pe_pkg::*;
#(
  parameter  int INT_BW = DEF_INT_BW,
  parameter  int FRA_BW = DEF_FRA_BW,
  parameter  int MUL_BW = DEF_MUL_BW,
  parameter  int ACC_BW = DEF_ACC_BW,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic [1:0]        gemm_uno,
  input  logic              in_vld,
  input  logic [ACC_BW-1:0] in_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [MUL_BW-1:0] out_data,
  output logic [1:0]        out_mode,
  output logic              out_sat,
  output logic [CNT_W-1:0]  count_o,
  output logic              ovf_o,
  output logic [15:0]       sat_cnt_o
);

  if (MUL_BW != 1 + INT_BW + FRA_BW || MUL_BW != DEF_MUL_BW) begin : g_bad_cfg
    $error("pe_out_drain: MUL_BW must equal 1+INT_BW+FRA_BW and the package entry width");
  end

  localparam logic signed [ACC_BW:0] Q_HI = (ACC_BW+1)'(2 ** (MUL_BW - 1) - 1);
  localparam logic signed [ACC_BW:0] Q_LO = ~Q_HI;
  localparam logic signed [ACC_BW:0] HALF = (ACC_BW+1)'(2 ** (FRA_BW - 1));

  logic              s1_vld_q, s1_vld_d;
  drain_entry_t      s1_entry_q, s1_entry_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       sat_cnt_q, sat_cnt_d;
  logic signed [ACC_BW:0] rnd_t, rnd_q;
  logic              sat_hi, sat_lo;

  drain_entry_t      head;
  logic              fifo_full, fifo_empty;

  // Sign-extend one bit so adding the half-LSB cannot wrap at the positive extreme.
  always_comb begin
    rnd_t  = $signed({in_data[ACC_BW-1], in_data}) + HALF;
    rnd_q  = rnd_t >>> FRA_BW;
    sat_hi = (rnd_q > Q_HI);
    sat_lo = (rnd_q < Q_LO);

    s1_entry_d      = '0;
    s1_entry_d.mode = gemm_uno_e'(gemm_uno);
    s1_entry_d.sat  = sat_hi | sat_lo;
    if (sat_hi)      s1_entry_d.data = MUL_MAX;
    else if (sat_lo) s1_entry_d.data = MUL_MIN;
    else             s1_entry_d.data = rnd_q[DEF_MUL_BW-1:0];
    s1_vld_d = in_vld & ~clr_i;

    ovf_d     = ovf_q | (s1_vld_q & fifo_full & ~out_rdy);
    sat_cnt_d = sat_cnt_q;
    if (s1_vld_q && s1_entry_q.sat && sat_cnt_q != 16'hFFFF) sat_cnt_d = sat_cnt_q + 1'b1;
    if (clr_i) begin
      ovf_d     = 1'b0;
      sat_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_entry_q <= '0;
      ovf_q      <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      s1_vld_q   <= s1_vld_d;
      s1_entry_q <= s1_entry_d;
      ovf_q      <= ovf_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  drain_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr_i),
    .push_i     (s1_vld_q),
    .wr_entry_i (s1_entry_q),
    .pop_i      (out_rdy),
    .rd_entry_o (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (count_o)
  );

  // Head fields read as zero when empty so reset/clear present clean outputs.
  assign out_vld   = ~fifo_empty;
  assign out_data  = out_vld ? MUL_BW'(head.data) : '0;
  assign out_mode  = out_vld ? head.mode : 2'b00;
  assign out_sat   = out_vld & head.sat;
  assign ovf_o     = ovf_q;
  assign sat_cnt_o = sat_cnt_q;

endmodule

// File: tb/tb_pe_out_drain.sv
// Directed bench for pe_out_drain with a queue-based reference model checked every cycle.
module tb_pe_out_drain;
  import pe_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr_i;
  logic [1:0]  gemm_uno;
  logic        in_vld;
  logic [31:0] in_data;
  logic        out_vld;
  logic        out_rdy;
  logic [15:0] out_data;
  logic [1:0]  out_mode;
  logic        out_sat;
  logic [2:0]  count_o;
  logic        ovf_o;
  logic [15:0] sat_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  pe_out_drain dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (clr_i),
    .gemm_uno  (gemm_uno),
    .in_vld    (in_vld),
    .in_data   (in_data),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .out_sat   (out_sat),
    .count_o   (count_o),
    .ovf_o     (ovf_o),
    .sat_cnt_o (sat_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] d;
    logic [1:0]  m;
    logic        s;
  } ent_t;

  ent_t        mq[$];
  logic        m_s1_vld = 1'b0;
  ent_t        m_s1     = '{d: 16'h0, m: 2'b00, s: 1'b0};
  logic        m_ovf    = 1'b0;
  int          m_sat_cnt = 0;

  function automatic ent_t requant(input logic [31:0] x, input logic [1:0] m);
    longint v;
    ent_t   e;
    v   = longint'($signed(x)) + 512;
    v   = v >>> 10;
    e.m = m;
    e.s = 1'b0;
    if (v > 32767) begin
      e.d = 16'h7FFF; e.s = 1'b1;
    end else if (v < -32768) begin
      e.d = 16'h8000; e.s = 1'b1;
    end else begin
      e.d = 16'(v);
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr_i) begin
      mq.delete();
      m_s1_vld  <= 1'b0;
      m_ovf     <= 1'b0;
      m_sat_cnt <= 0;
    end else begin
      automatic bit do_pop = (mq.size() > 0) && out_rdy;
      automatic bit full   = (mq.size() == DEPTH);
      if (m_s1_vld && m_s1.s && m_sat_cnt < 16'hFFFF) m_sat_cnt <= m_sat_cnt + 1;
      if (do_pop) void'(mq.pop_front());
      if (m_s1_vld) begin
        if (full && !do_pop) m_ovf <= 1'b1;
        else mq.push_back(m_s1);
      end
      m_s1_vld <= in_vld;
      m_s1     <= requant(in_data, gemm_uno);
    end
  end

  // Compare DUT against model on every falling edge.
  always @(negedge clk) begin
    check("out_vld", 32'(out_vld), 32'(mq.size() != 0));
    check("count_o", 32'(count_o), 32'(mq.size()));
    check("ovf_o", 32'(ovf_o), 32'(m_ovf));
    check("sat_cnt_o", 32'(sat_cnt_o), 32'(m_sat_cnt));
    if (mq.size() != 0) begin
      check("out_data", 32'(out_data), 32'(mq[0].d));
      check("out_mode", 32'(out_mode), 32'(mq[0].m));
      check("out_sat", 32'(out_sat), 32'(mq[0].s));
    end else begin
      check("out_data_empty", 32'(out_data), 32'h0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] m, input logic rdy);
    tick();
    in_vld   = v;
    in_data  = d;
    gemm_uno = m;
    out_rdy  = rdy;
  endtask

  task automatic send_check(input string name, input logic [31:0] d, input logic [1:0] m,
                            input logic [15:0] exp, input logic exp_sat);
    drive(1'b1, d, m, 1'b1);
    drive(1'b0, 32'h0, GEMM, 1'b1);
    tick();
    check({name, "_vld"}, 32'(out_vld), 32'h1);
    check({name, "_data"}, 32'(out_data), 32'(exp));
    check({name, "_sat"}, 32'(out_sat), 32'(exp_sat));
    check({name, "_mode"}, 32'(out_mode), 32'(m));
  endtask

  logic [15:0] drain_exp [4];

  initial begin
    rst_n = 1'b0; clr_i = 1'b0; in_vld = 1'b0; in_data = '0; gemm_uno = GEMM; out_rdy = 1'b0;
    repeat (2) tick();
    check("rst_out_vld", 32'(out_vld), 32'h0);
    check("rst_count", 32'(count_o), 32'h0);
    check("rst_data", 32'(out_data), 32'h0);
    rst_n = 1'b1;
    tick();

    send_check("nominal", 32'h0010_0000, GEMM, 16'h0400, 1'b0);
    send_check("rnd_p_up", 32'h0000_0200, DIV, 16'h0001, 1'b0);
    send_check("rnd_p_dn", 32'h0000_01FF, GEMM, 16'h0000, 1'b0);
    send_check("rnd_n_up", 32'hFFFF_FE00, LOG, 16'h0000, 1'b0);
    send_check("rnd_n_dn", 32'hFFFF_FDFF, GEMM, 16'hFFFF, 1'b0);
    send_check("sat_max", 32'h7FFF_FFFF, GEMM, 16'h7FFF, 1'b1);
    send_check("sat_min", 32'h8000_0000, GEMM, 16'h8000, 1'b1);
    send_check("sat_rnd", 32'h01FF_FE00, GEMM, 16'h7FFF, 1'b1);
    check("sat_cnt_3", 32'(sat_cnt_o), 32'd3);

    // Overflow: five back-to-back pushes into a stalled four-entry FIFO.
    for (int i = 1; i <= 5; i++) drive(1'b1, 32'(i) << 20, EXP, 1'b0);
    drive(1'b0, 32'h0, GEMM, 1'b0);
    tick();
    check("ovf_count", 32'(count_o), 32'd4);
    check("ovf_flag", 32'(ovf_o), 32'h1);
    check("ovf_head", 32'(out_data), 32'h0400);
    check("ovf_mode", 32'(out_mode), 32'(EXP));

    // Push and pop on the same edge while full.
    drive(1'b1, 32'h0060_0000, EXP, 1'b0);
    drive(1'b0, 32'h0, GEMM, 1'b1);
    drive(1'b0, 32'h0, GEMM, 1'b0);
    check("pp_count", 32'(count_o), 32'd4);
    check("pp_ovf", 32'(ovf_o), 32'h1);
    check("pp_head", 32'(out_data), 32'h0800);
    drain_exp[0] = 16'h0800; drain_exp[1] = 16'h0C00;
    drain_exp[2] = 16'h1000; drain_exp[3] = 16'h1800;
    out_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain%0d_data", k), 32'(out_data), 32'(drain_exp[k]));
      check($sformatf("drain%0d_mode", k), 32'(out_mode), 32'(EXP));
      tick();
    end
    check("drain_empty", 32'(out_vld), 32'h0);

    // Asynchronous reset with three entries queued.
    for (int i = 1; i <= 3; i++) drive(1'b1, 32'(i) << 20, GEMM, 1'b0);
    drive(1'b0, 32'h0, GEMM, 1'b0);
    tick();
    check("pre_rst_count", 32'(count_o), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 32'(out_vld), 32'h0);
    check("mid_rst_count", 32'(count_o), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Synchronous clear of sticky flag and counter.
    for (int i = 0; i < 5; i++) drive(1'b1, 32'h7FFF_FFFF, LOG, 1'b0);
    drive(1'b0, 32'h0, GEMM, 1'b0);
    tick();
    check("pre_clr_ovf", 32'(ovf_o), 32'h1);
    check("pre_clr_sat", 32'(sat_cnt_o), 32'd5);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    check("clr_ovf", 32'(ovf_o), 32'h0);
    check("clr_sat", 32'(sat_cnt_o), 32'h0);
    check("clr_count", 32'(count_o), 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_out_drain.md
Name: pe_out_drain

Overview:
- Downstream consumer of a PE column's result register (oreg, exposed as mac_o/o_o): captures ACC_BW fixed-point results at the bottom of the array.
- Requantizes results from Q(2*FRA_BW) fraction to the MUL_BW Q(INT_BW.FRA_BW) operand format: round-half-up, then saturate.
- Buffers results in a small FIFO with a valid/ready handshake towards the writeback/next-layer path.
- The PE has no backpressure, so the drain detects and flags overflow instead of stalling.

Parameters:
- INT_BW, 5, integer bits of MUL_BW operand format (excluding sign)
- FRA_BW, 10, fractional bits of MUL_BW operand format; input carries 2*FRA_BW fractional bits
- MUL_BW, 16, output data width; equals 1+INT_BW+FRA_BW
- ACC_BW, 32, input accumulator width
- DEPTH, 4, FIFO entries; power of two, >=2

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- clr_i  in  1  synchronous flush of pipeline, FIFO, flags and counters
- gemm_uno  in  2  mode tag sampled with in_vld (00 gemm, 01 div, 10 exp, 11 log)
- in_vld  in  1  in_data valid this cycle
- in_data  in  ACC_BW  signed PE result (o_o)
- out_vld  out  1  FIFO head valid
- out_rdy  in  1  consumer accepts head
- out_data  out  MUL_BW  signed requantized result at head
- out_mode  out  2  mode tag stored with head entry
- out_sat  out  1  head entry was saturated
- count_o  out  clog2(DEPTH+1)  FIFO occupancy
- ovf_o  out  1  sticky: a result was dropped because the FIFO was full
- sat_cnt_o  out  16  saturating count of saturation events

Behaviour:
- Reset and clr_i: out_vld=0, count_o=0, ovf_o=0, sat_cnt_o=0; stage-1 register invalid; out_data/out_mode/out_sat=0. clr_i has priority over all same-cycle events.
- Stage 1 (registered), on the edge sampling in_vld=1:
  - t = sign-extended in_data (ACC_BW+1 bits) + 2^(FRA_BW-1).
  - q = t >>> FRA_BW (arithmetic shift).
  - If q > 2^(MUL_BW-1)-1, output 0x7FFF.. and set sat. If q < -2^(MUL_BW-1), output 0x8000.. and set sat. Otherwise output q[MUL_BW-1:0].
  - Mode tag and sat bit are registered alongside the data.
- Stage 2: a valid stage-1 entry is written into the FIFO on the next edge.
  - Latency: in_vld at edge E → out_vld=1 after edge E+1 when the FIFO was empty and no pop occurred.
  - Throughput: 1 result per cycle.
- Pop: out_vld & out_rdy on an edge removes the head. out_data, out_mode and out_sat are the head entry, driven combinationally from the FIFO array.
- Full:
  - Push while count_o==DEPTH with no same-cycle pop → entry dropped, FIFO contents unchanged, ovf_o set until clr_i or reset.
  - Push and pop in the same cycle while full → both occur, count unchanged, no overflow.
- Empty: out_vld=0; out_rdy is ignored.
- Pointers: log2(DEPTH)-bit read/write pointers wrap modulo DEPTH. count_o is tracked separately: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- sat_cnt_o: increments when a saturated entry leaves stage 1, whether or not it is later dropped; holds at 0xFFFF.
- Reset mid-operation: all state clears immediately (asynchronous); in-flight stage-1 data is lost.
- No combinational path from in_* to out_*. out_vld depends on FIFO state only.

Decomposition:
- Shared package pe_pkg holds:
  - gemm_uno_e enum (GEMM=2'b00, DIV=2'b01, EXP=2'b10, LOG=2'b11).
  - Q-format constants: default INT_BW/FRA_BW/MUL_BW/ACC_BW, MUL_MAX, MUL_MIN.
  - drain_entry_t struct {data, mode, sat}.
- One sub-module, drain_fifo: a synchronous FIFO of drain_entry_t with DEPTH parameter, push/pop/full/empty/count.
- Rounding and saturation stay inline in pe_out_drain.

Test Plan:
- Nominal value: in_data=0x0010_0000 (1.0), mode GEMM, out_rdy=1 → out_data=0x0400 two edges later, out_sat=0, out_mode=00.
- Rounding boundaries:
  - 0x0000_0200 → 0x0001.
  - 0x0000_01FF → 0x0000.
  - 0xFFFF_FE00 → 0x0000.
  - 0xFFFF_FDFF → 0xFFFF.
- Saturation:
  - 0x7FFF_FFFF → 0x7FFF, out_sat=1.
  - 0x8000_0000 → 0x8000, out_sat=1.
  - 0x01FF_FE00 → 0x7FFF, out_sat=1 (rounding pushes it over the limit).
  - After these three, sat_cnt_o=3.
- Overflow: out_rdy=0, DEPTH=4, push 5 consecutive values 1.0..5.0 (mode EXP) → count_o=4, ovf_o=1; raising out_rdy drains 0x0400, 0x0800, 0x0C00, 0x1000 in order, all out_mode=10.
- Full push+pop: FIFO full, push 6.0 in the same cycle as a pop → count_o stays 4, ovf_o unchanged, 0x1800 becomes the tail.
- Reset and clear:
  - Assert rst_n=0 mid-stream with 3 entries queued → out_vld=0, count_o=0 immediately.
  - Assert clr_i for 1 cycle with ovf_o=1 → ovf_o=0 and sat_cnt_o=0 on the next cycle.
